// File: rtl/ppu_frame_pkg.sv
// Shared types and constants for the PPU framebuffer writer.
package ppu_frame_pkg;

  typedef enum logic [1:0] {
    SYNC,
    ACTIVE,
    DONE
  } state_t;

  localparam int unsigned FRAME_PIXELS = 61440;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nx;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_nx   = rd_ptr + AW'(1);

  // Storage array; no reset needed since reads are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head entry.
  // The head register mirrors mem[rd_ptr]; when the entry behind the head is
  // being written in the same cycle it is taken straight from din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nx;
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (do_pop) begin
        if (count == (AW+1)'(1)) dout <= do_push ? din : '0;
        else                     dout <= mem[rd_nx];
      end else if (do_push && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/ppu_frame_writer.sv
// Converts the PPU pixel stream into addressed framebuffer writes and
// checks frame geometry.
module ppu_frame_writer
  import ppu_frame_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned H_PIXELS   = 256,
  parameter int unsigned V_LINES    = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixel,
  input  logic        pixel_en,
  input  logic        vblank,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        err_overflow,
  output logic        err_short,
  output logic        err_long,
  input  logic        err_clr
);

  localparam logic [15:0] LAST_ADDR = 16'(H_PIXELS * V_LINES - 1);

  state_t      state, state_nx;
  logic        vblank_q;
  logic        vb_rise, vb_fall;
  logic [15:0] x, y, addr;
  logic        last_px;
  logic        take, clr_xy, set_short, set_long, set_ovf;
  logic        pop, full, empty;
  fifo_entry_t entry_in, entry_out;

  assign vb_rise = vblank && !vblank_q;
  assign vb_fall = !vblank && vblank_q;
  assign last_px = (x == 16'(H_PIXELS - 1)) && (y == 16'(V_LINES - 1));

  // State register and vblank edge reference (resets high so an initial low
  // vblank counts as a falling edge).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SYNC;
      vblank_q <= 1'b1;
    end else begin
      state    <= state_nx;
      vblank_q <= vblank;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    clr_xy    = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state)
      SYNC: if (vb_fall) state_nx = ACTIVE;
      ACTIVE: begin
        if (vb_rise) begin
          set_short = 1'b1;
          clr_xy    = 1'b1;
          state_nx  = SYNC;
        end else if (pixel_en) begin
          take = 1'b1;
          if (last_px) begin
            clr_xy   = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        set_long = pixel_en;
        if (vb_rise) begin
          clr_xy   = 1'b1;
          state_nx = SYNC;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // Raster position; addr advances with every taken pixel, which keeps it
  // equal to y*H_PIXELS + x (mod 2^16) without a multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clr_xy) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (take) begin
      addr <= addr + 16'd1;
      if (x == 16'(H_PIXELS - 1)) begin
        x <= '0;
        y <= y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

  assign entry_in = '{addr: addr, data: pixel};
  assign pop      = wr_valid && wr_ready;
  assign set_ovf  = take && full && !pop;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (take),
    .pop   (pop),
    .din   (entry_in),
    .dout  (entry_out),
    .full  (full),
    .empty (empty)
  );

  assign wr_valid = !empty;
  assign wr_addr  = entry_out.addr;
  assign wr_data  = entry_out.data;

  // Frame completion tracks the write of the final address leaving the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= pop && (wr_addr == LAST_ADDR);
      if (pop && (wr_addr == LAST_ADDR)) frame_count <= frame_count + 16'd1;
    end
  end

  // Sticky error flags; a clear wins over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else if (err_clr) begin
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      err_overflow <= err_overflow | set_ovf;
      err_short    <= err_short | set_short;
      err_long     <= err_long | set_long;
    end
  end

endmodule

// File: doc/ppu_frame_writer.md
# ppu_frame_writer

Downstream consumer of the NES core's video output. Takes the PPU pixel stream (`pixel`, `pixel_en`, `vblank`) and turns it into addressed framebuffer writes (`y*256 + x`) through a small elastic FIFO with a valid/ready handshake. The consumer is a BRAM, an HDMI line buffer or a bench frame dumper. The block also checks frame geometry and reports timing errors so that simulation and FPGA builds can detect PPU pixel-count regressions.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 4: elastic buffer entries. Must be a power of 2 and at least 2.
- `H_PIXELS`, default 256: active pixels per line.
- `V_LINES`, default 240: active lines per frame.

**Ports**
- `clk` in 1: pixel clock (the PPU clock domain).
- `rst` in 1: asynchronous, active-high reset.
- `pixel` in 8: palette index / colour byte.
- `pixel_en` in 1: `pixel` is valid this cycle.
- `vblank` in 1: PPU vertical blank level.
- `wr_addr` out 16: framebuffer address, `y*H_PIXELS + x`.
- `wr_data` out 8: pixel value.
- `wr_valid` out 1: a write is presented.
- `wr_ready` in 1: the consumer accepts the write.
- `frame_done` out 1: one-cycle pulse.
- `frame_count` out 16: number of completed frames, wraps.
- `err_overflow` out 1: sticky flag.
- `err_short` out 1: sticky flag.
- `err_long` out 1: sticky flag.
- `err_clr` in 1: clears all three sticky error flags.

## Operation

**States.** The FSM has three states: SYNC, ACTIVE and DONE. Reset enters SYNC.
- **SYNC:** ignore pixels. Go to ACTIVE on a falling edge of `vblank` (previous cycle 1, current cycle 0).
- **ACTIVE:** each `pixel_en` pushes `{addr, pixel}` into the FIFO.
  - `x` counts 0..`H_PIXELS`-1. At the wrap, `y` increments.
  - When push number `H_PIXELS*V_LINES` is taken, go to DONE.
  - A rising edge of `vblank` while in ACTIVE sets `err_short`, resets `x` and `y` to 0, and goes to SYNC. Pixels of the partial frame already in the FIFO still drain.
- **DONE:** `pixel_en` is dropped and sets `err_long`. A rising edge of `vblank` goes to SYNC with `x` and `y` reset to 0.

**Address arithmetic.** The address is computed as `{y[7:0], x[7:0]}` for the default parameters, in general `y*H_PIXELS + x` truncated to 16 bits. The last address of a frame is 0xEFFF.

**FIFO.**
- A push when the FIFO is full and no pop happens in the same cycle: the pixel is dropped, `err_overflow` is set, and the `x`/`y` counters still advance so geometry stays aligned.
- A push and a pop in the same cycle while full: the push is accepted, no error.
- A pop occurs when `wr_valid && wr_ready`.

**Completion outputs.**
- `frame_done` pulses in the cycle after the handshake of the write carrying address `H_PIXELS*V_LINES-1`.
- `frame_count` increments in that same cycle.

**Error flags.**
- `err_clr` has priority over a same-cycle error set, so the flag clears.
- A mid-stream `rst` empties the FIFO, clears all flags and counters, and returns to SYNC.

## Timing

**Reset values.** `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `frame_count`=0, all `err_*`=0. State = SYNC, `x`=`y`=0.

**Latency.** A pixel pushed on edge N to an empty FIFO is presented with `wr_valid` high after edge N (one cycle). The FIFO outputs are registered.

**Handshake rules.**
- `wr_addr` and `wr_data` are held stable while `wr_valid && !wr_ready`.
- `wr_valid` never drops without a handshake, except on `rst`.

**Throughput.** Sustained one write per clock when `wr_ready` is held high.

**Edge detection.** `vblank` edges are detected against a one-cycle registered copy of `vblank`. The registered copy resets to 1, so the first low `vblank` after reset counts as a falling edge.

## Structure

**Package `ppu_frame_pkg`:**
- `state_t` enum (SYNC, ACTIVE, DONE).
- `FRAME_PIXELS` = 61440.
- The `fifo_entry_t` struct: `addr`[15:0], `data`[7:0].

**Sub-module `sync_fifo`:** a parameterised FIFO with depth and width parameters. It provides `push`, `pop`, `full`, `empty` and registered output data, and it reuses `clk`/`rst`. The top-level logic keeps the FSM, the counters and the error flags.

## Test plan

1. **Clean frame.** Stimulus: reset, `vblank` 1→0, then 61440 `pixel_en` pulses with `pixel`=addr[7:0], `wr_ready`=1. Required response: 61440 writes, addr 0x0000..0xEFFF in order, data matching, `frame_done` pulsing exactly once, `frame_count`=1, no errors.
2. **Backpressure.** Stimulus: `wr_ready` toggled 1/0 each cycle while pixels arrive every 2nd cycle. Required response: no loss, data stable while stalled, `err_overflow`=0.
3. **Overflow.** Stimulus: `wr_ready`=0, push 5 pixels with `FIFO_DEPTH`=4. Required response: `err_overflow`=1, 4 writes drain with addresses 0..3, and the next pixel pushed after the drop gets addr 5.
4. **Short frame.** Stimulus: `vblank` rises after 1000 pixels. Required response: `err_short`=1, no `frame_done`, and the next frame restarts at addr 0x0000.
5. **Long frame plus clear.** Stimulus: 61441 pixels, then `err_clr`. Required response: `err_long`=1, still exactly 61440 writes; after `err_clr`, the flag reads 0.
6. **Reset mid-frame.** Stimulus: `rst` asserted at pixel 30000 with the FIFO non-empty. Required response: `wr_valid`=0 immediately, all flags and counters 0, and pixels ignored until the next `vblank` fall.
